relu_drain: RTL and testbench

- Reader at the far end of the ReLU stage's ready interface.
- Captures the 4-neuron x 4-output ReLU result block when the stage raises relu_ready.
- Requantizes each value: arithmetic right shift, then clamp to the OUT_SIZE signed range.
- Streams the block to the next layer one neuron (4 values) per beat over a valid/ready handshake, and flags blocks lost while busy.

---
 rtl/relu_drain_if.sv | 23 ++
 rtl/relu_drain.sv | 150 +++++++++++++++
 tb/tb_relu_drain.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_drain_if.sv
// Output stream of the ReLU drain: one neuron (four requantized values) per beat,
// transferred on out_valid & out_ready.
interface relu_drain_if #(
    parameter int OUT_SIZE = 8
);
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 out_idx;
    logic signed [OUT_SIZE-1:0] out_d0;
    logic signed [OUT_SIZE-1:0] out_d1;
    logic signed [OUT_SIZE-1:0] out_d2;
    logic signed [OUT_SIZE-1:0] out_d3;

    modport master (
        output out_valid, out_idx, out_d0, out_d1, out_d2, out_d3,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_idx, out_d0, out_d1, out_d2, out_d3,
        output out_ready
    );
endinterface

// File: rtl/relu_drain.sv
// Captures a 4x4 ReLU result block on a relu_ready rising edge, requantizes it
// (shift then saturate) and streams it out one neuron per beat.
module relu_drain #(
    parameter int RELU4_SIZE = 21,
    parameter int OUT_SIZE   = 8,
    parameter int SHIFT      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         relu_ready,
    input  logic signed [RELU4_SIZE-1:0] in0_n0,
    input  logic signed [RELU4_SIZE-1:0] in1_n0,
    input  logic signed [RELU4_SIZE-1:0] in2_n0,
    input  logic signed [RELU4_SIZE-1:0] in3_n0,
    input  logic signed [RELU4_SIZE-1:0] in0_n1,
    input  logic signed [RELU4_SIZE-1:0] in1_n1,
    input  logic signed [RELU4_SIZE-1:0] in2_n1,
    input  logic signed [RELU4_SIZE-1:0] in3_n1,
    input  logic signed [RELU4_SIZE-1:0] in0_n2,
    input  logic signed [RELU4_SIZE-1:0] in1_n2,
    input  logic signed [RELU4_SIZE-1:0] in2_n2,
    input  logic signed [RELU4_SIZE-1:0] in3_n2,
    input  logic signed [RELU4_SIZE-1:0] in0_n3,
    input  logic signed [RELU4_SIZE-1:0] in1_n3,
    input  logic signed [RELU4_SIZE-1:0] in2_n3,
    input  logic signed [RELU4_SIZE-1:0] in3_n3,
    input  logic                         clr_ovf,
    relu_drain_if.master                 bus,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic signed [RELU4_SIZE-1:0] Q_MAX = RELU4_SIZE'((1 << (OUT_SIZE - 1)) - 1);

    state_t                       state_q, state_d;
    logic [1:0]                   k_q, k_d;
    logic                         relu_ready_q;
    logic                         rise;
    logic                         capture;
    logic                         ovf_set;
    logic                         done_d, done_q;
    logic                         overflow_q;
    logic                         sending;
    logic signed [RELU4_SIZE-1:0] in_arr [4][4];
    logic signed [RELU4_SIZE-1:0] buf_q  [4][4];

    // in_arr / buf_q are indexed [neuron][output]
    assign in_arr[0][0] = in0_n0;
    assign in_arr[0][1] = in1_n0;
    assign in_arr[0][2] = in2_n0;
    assign in_arr[0][3] = in3_n0;
    assign in_arr[1][0] = in0_n1;
    assign in_arr[1][1] = in1_n1;
    assign in_arr[1][2] = in2_n1;
    assign in_arr[1][3] = in3_n1;
    assign in_arr[2][0] = in0_n2;
    assign in_arr[2][1] = in1_n2;
    assign in_arr[2][2] = in2_n2;
    assign in_arr[2][3] = in3_n2;
    assign in_arr[3][0] = in0_n3;
    assign in_arr[3][1] = in1_n3;
    assign in_arr[3][2] = in2_n3;
    assign in_arr[3][3] = in3_n3;

    // Negative values (impossible after ReLU, kept defensive) clamp to zero.
    function automatic logic signed [OUT_SIZE-1:0] requant(input logic signed [RELU4_SIZE-1:0] x);
        logic signed [RELU4_SIZE-1:0] t;
        t = x >>> SHIFT;
        if (t[RELU4_SIZE-1])
            return '0;
        else if (t > Q_MAX)
            return Q_MAX[OUT_SIZE-1:0];
        else
            return t[OUT_SIZE-1:0];
    endfunction

    assign rise = relu_ready & ~relu_ready_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        done_d  = 1'b0;
        capture = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    state_d = SEND;
                    k_d     = 2'd0;
                end
            end
            SEND: begin
                ovf_set = rise;
                if (bus.out_ready) begin
                    if (k_q == 2'd3) begin
                        state_d = IDLE;
                        k_d     = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the capture buffer is reset along with the control state so out_d reads zero after reset; 16 words is small enough to keep in flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= 2'd0;
            relu_ready_q <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            for (int n = 0; n < 4; n++)
                for (int j = 0; j < 4; j++)
                    buf_q[n][j] <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            relu_ready_q <= relu_ready;
            done_q       <= done_d;
            if (ovf_set)
                overflow_q <= 1'b1;
            else if (clr_ovf)
                overflow_q <= 1'b0;
            if (capture)
                buf_q <= in_arr;
        end
    end

    // Beat outputs are decoded from registers only, so they cannot move while a beat waits.
    assign sending       = (state_q == SEND);
    assign bus.out_valid = sending;
    assign bus.out_idx   = k_q;
    assign bus.out_d0    = sending ? requant(buf_q[k_q][0]) : '0;
    assign bus.out_d1    = sending ? requant(buf_q[k_q][1]) : '0;
    assign bus.out_d2    = sending ? requant(buf_q[k_q][2]) : '0;
    assign bus.out_d3    = sending ? requant(buf_q[k_q][3]) : '0;
    assign busy          = sending;
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_relu_drain.sv
// Directed sequence with randomized block contents, checked against a plain
// arithmetic model of the requantizer and the beat ordering.
module tb_relu_drain;

    localparam int RELU4_SIZE = 21;
    localparam int OUT_SIZE   = 8;
    localparam int SHIFT      = 4;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic relu_ready = 1'b0;
    logic clr_ovf    = 1'b0;
    logic busy, done, overflow;
    logic signed [RELU4_SIZE-1:0] blk [16];   // blk[neuron*4 + output]
    int   exp_q [16];
    int   n_checks = 0;
    int   n_fail   = 0;

    relu_drain_if #(.OUT_SIZE(OUT_SIZE)) bus ();

    relu_drain #(.RELU4_SIZE(RELU4_SIZE), .OUT_SIZE(OUT_SIZE), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .relu_ready(relu_ready),
        .in0_n0(blk[0]),  .in1_n0(blk[1]),  .in2_n0(blk[2]),  .in3_n0(blk[3]),
        .in0_n1(blk[4]),  .in1_n1(blk[5]),  .in2_n1(blk[6]),  .in3_n1(blk[7]),
        .in0_n2(blk[8]),  .in1_n2(blk[9]),  .in2_n2(blk[10]), .in3_n2(blk[11]),
        .in0_n3(blk[12]), .in1_n3(blk[13]), .in2_n3(blk[14]), .in3_n3(blk[15]),
        .clr_ovf(clr_ovf), .bus(bus), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference requantizer: divide by 2^SHIFT, saturate to the positive output range.
    function automatic int q_ref(input int x);
        int t;
        int hi;
        hi = (1 << (OUT_SIZE - 1)) - 1;
        if (x < 0) return 0;
        t = x / (1 << SHIFT);
        return (t > hi) ? hi : t;
    endfunction

    function automatic logic signed [RELU4_SIZE-1:0] rand_val();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 2047));
            1:       v = int'($urandom_range(2020, 2100));
            2:       v = int'($urandom_range(0, (1 << 20) - 1));
            default: v = -int'($urandom_range(1, 500));
        endcase
        return RELU4_SIZE'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) blk[i] = rand_val();
    endtask

    // Snapshot of what the block on the inputs should look like once drained.
    task automatic capture_model();
        for (int i = 0; i < 16; i++) exp_q[i] = q_ref(int'(blk[i]));
    endtask

    task automatic check_beat(input int k);
        check($sformatf("beat%0d valid", k), 32'(bus.out_valid), 32'd1);
        check($sformatf("beat%0d busy", k),  32'(busy),          32'd1);
        check($sformatf("beat%0d idx", k),   32'(bus.out_idx),   32'(k));
        check($sformatf("beat%0d d0", k),    32'(bus.out_d0),    32'(exp_q[k*4+0]));
        check($sformatf("beat%0d d1", k),    32'(bus.out_d1),    32'(exp_q[k*4+1]));
        check($sformatf("beat%0d d2", k),    32'(bus.out_d2),    32'(exp_q[k*4+2]));
        check($sformatf("beat%0d d3", k),    32'(bus.out_d3),    32'(exp_q[k*4+3]));
    endtask

    task automatic check_done();
        check("done pulse", 32'(done),          32'd1);
        check("done valid", 32'(bus.out_valid), 32'd0);
        check("done busy",  32'(busy),          32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = '0;

        // Reset state
        #12;
        check("rst valid",    32'(bus.out_valid), 32'd0);
        check("rst busy",     32'(busy),          32'd0);
        check("rst done",     32'(done),          32'd0);
        check("rst overflow", 32'(overflow),      32'd0);
        check("rst idx",      32'(bus.out_idx),   32'd0);
        check("rst d0",       32'(bus.out_d0),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic drain: 16*(1..16) -> 1..16
        for (int i = 0; i < 16; i++) blk[i] = RELU4_SIZE'(16 * (i + 1));
        capture_model();
        relu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        @(negedge clk);
        check_done();
        relu_ready = 1'b0;
        @(negedge clk);
        check("basic done once", 32'(done), 32'd0);
        check("basic no ovf", 32'(overflow), 32'd0);

        // Saturation and clamp on neuron 0
        load_random();
        blk[0] = 21'sd100000;
        blk[1] = 21'sd2032;
        blk[2] = 21'sd2047;
        blk[3] = -21'sd64;
        capture_model();
        relu_ready = 1'b1;
        @(negedge clk);
        check("sat d0", 32'(bus.out_d0), 32'd127);
        check("sat d1", 32'(bus.out_d1), 32'd127);
        check("sat d2", 32'(bus.out_d2), 32'd127);
        check("sat d3", 32'(bus.out_d3), 32'd0);
        check_beat(0);
        relu_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        @(negedge clk);
        check_done();

        // Backpressure: beat 1 held for 5 cycles
        load_random();
        capture_model();
        relu_ready = 1'b1;
        @(negedge clk);
        check_beat(0);
        relu_ready = 1'b0;
        @(negedge clk);
        check_beat(1);
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_beat(1);
        end
        bus.out_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        @(negedge clk);
        check_done();

        // Overflow: second rise during beat 2 is discarded
        load_random();
        capture_model();
        relu_ready = 1'b1;
        @(negedge clk);
        check_beat(0);
        relu_ready = 1'b0;
        @(negedge clk);
        check_beat(1);
        @(negedge clk);
        check_beat(2);
        load_random();
        relu_ready = 1'b1;
        @(negedge clk);
        check("ovf set", 32'(overflow), 32'd1);
        check_beat(3);
        @(negedge clk);
        check_done();
        check("ovf sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf cleared", 32'(overflow), 32'd0);
        check("ovf no recapture", 32'(bus.out_valid), 32'd0);
        relu_ready = 1'b0;
        @(negedge clk);

        // Set wins over a coincident clear
        load_random();
        capture_model();
        relu_ready = 1'b1;
        @(negedge clk);
        check_beat(0);
        relu_ready = 1'b0;
        @(negedge clk);
        check_beat(1);
        relu_ready = 1'b1;
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        relu_ready = 1'b0;
        check("ovf set wins", 32'(overflow), 32'd1);
        check_beat(2);
        @(negedge clk);
        check_beat(3);
        @(negedge clk);
        check_done();
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf cleared 2", 32'(overflow), 32'd0);

        // Level held high for 20 cycles yields one block only
        load_random();
        capture_model();
        relu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        @(negedge clk);
        check_done();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check($sformatf("hold idle %0d", c), 32'(bus.out_valid), 32'd0);
        end
        relu_ready = 1'b0;
        @(negedge clk);

        // Re-arm: drop during beat 3, rise again in the done cycle
        load_random();
        capture_model();
        relu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        relu_ready = 1'b0;
        @(negedge clk);
        check_done();
        load_random();
        capture_model();
        relu_ready = 1'b1;
        @(negedge clk);
        check_beat(0);
        check("rearm no ovf", 32'(overflow), 32'd0);
        relu_ready = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        @(negedge clk);
        check_done();
        check("rearm no ovf end", 32'(overflow), 32'd0);

        // Asynchronous reset in the middle of beat 1
        load_random();
        capture_model();
        relu_ready = 1'b1;
        @(negedge clk);
        check_beat(0);
        relu_ready = 1'b0;
        @(negedge clk);
        check_beat(1);
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", 32'(bus.out_valid), 32'd0);
        check("arst busy",  32'(busy),          32'd0);
        check("arst idx",   32'(bus.out_idx),   32'd0);
        check("arst d0",    32'(bus.out_d0),    32'd0);
        check("arst d3",    32'(bus.out_d3),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("arst no done %0d", c), 32'(done), 32'd0);
            check($sformatf("arst idle %0d", c), 32'(bus.out_valid), 32'd0);
        end
        load_random();
        capture_model();
        relu_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_beat(k);
        end
        relu_ready = 1'b0;
        @(negedge clk);
        check_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
